// File: rtl/signal_pkg.sv
// Shared types, default character patterns and the popcount helper for the
// octet-lane signal checker.
package signal_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    localparam logic [7:0] DATA_CHAR_DEFAULT = 8'hAA;
    localparam logic [7:0] CTRL_CHAR_DEFAULT = 8'h55;

    localparam int unsigned POP_MAX_W = 64;
    localparam int unsigned POP_CNT_W = 7;

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec);
        logic [POP_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(POP_MAX_W); i++) begin
            cnt = cnt + POP_CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/signal_lane_check.sv
// Compares one octet lane against the pattern selected by its control flag.
module signal_lane_check
    import signal_pkg::*;
#(
    parameter logic [7:0] DATA_PATTERN = DATA_CHAR_DEFAULT,
    parameter logic [7:0] CTRL_PATTERN = CTRL_CHAR_DEFAULT
) (
    input  logic [7:0] octet_i,
    input  logic       ctrl_i,
    output logic       mismatch_c_o
);

    assign mismatch_c_o = (octet_i != (ctrl_i ? CTRL_PATTERN : DATA_PATTERN));

endmodule

// File: rtl/signal_checker.sv
// Receive-side checker: per-lane pattern compare, HUNT/LOCKED lock tracking,
// saturating error count and windowed data/control character ratio.
module signal_checker
    import signal_pkg::*;
#(
    parameter int unsigned DATA_WIDTH            = 64,
    parameter logic [7:0]  DATA_CHAR_PATTERN     = DATA_CHAR_DEFAULT,
    parameter logic [7:0]  CTRL_CHAR_PATTERN     = CTRL_CHAR_DEFAULT,
    parameter int unsigned DATA_CHAR_PROBABILITY = 70,
    parameter int unsigned RATIO_TOLERANCE       = 10,
    parameter int unsigned WINDOW_CYCLES         = 1024,
    parameter int unsigned LOCK_CYCLES           = 16,
    parameter int unsigned UNLOCK_CYCLES         = 4,
    localparam int unsigned LANES = DATA_WIDTH / 8,
    localparam int unsigned CW    = $clog2(WINDOW_CYCLES * LANES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LANES-1:0]      ctrl_in,
    input  logic                  clear,
    output logic [LANES-1:0]      lane_err,
    output logic                  locked,
    output logic [31:0]           err_count,
    output logic [CW-1:0]         data_count,
    output logic [CW-1:0]         ctrl_count,
    output logic                  window_done,
    output logic                  ratio_ok
);

    localparam int unsigned WW      = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned RUN_MAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned RW      = $clog2(RUN_MAX + 1);
    localparam int unsigned TOTAL   = WINDOW_CYCLES * LANES;
    localparam int unsigned LO_PCT  = (DATA_CHAR_PROBABILITY > RATIO_TOLERANCE) ?
                                      DATA_CHAR_PROBABILITY - RATIO_TOLERANCE : 0;
    localparam int unsigned HI_PCT  = (DATA_CHAR_PROBABILITY + RATIO_TOLERANCE > 100) ?
                                      100 : DATA_CHAR_PROBABILITY + RATIO_TOLERANCE;
    localparam int unsigned LO_T    = LO_PCT * TOTAL;
    localparam int unsigned HI_T    = HI_PCT * TOTAL;

    logic [LANES-1:0] mismatch_c;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        signal_lane_check #(
            .DATA_PATTERN (DATA_CHAR_PATTERN),
            .CTRL_PATTERN (CTRL_CHAR_PATTERN)
        ) u_lane (
            .octet_i      (data_in[i*8 +: 8]),
            .ctrl_i       (ctrl_in[i]),
            .mismatch_c_o (mismatch_c[i])
        );
    end

    lock_state_t             state_q, state_d;
    logic [RW-1:0]           run_q, run_d;
    logic [WW-1:0]           wcnt_q, wcnt_d;
    logic [CW-1:0]           dacc_q, dacc_d, cacc_q, cacc_d;
    logic [CW-1:0]           dcnt_q, dcnt_d, ccnt_q, ccnt_d;
    logic [31:0]             err_q, err_d;
    logic [LANES-1:0]        lane_err_q, lane_err_d;
    logic                    locked_q, locked_d;
    logic                    done_q, done_d;
    logic                    ratio_q, ratio_d;

    logic                    errored_c;
    logic [POP_CNT_W-1:0]    err_pop_c, ctrl_pop_c;
    logic [32:0]             err_sum_c;
    logic [CW-1:0]           dsum_c, csum_c;
    logic [31:0]             dscaled_c;

    assign errored_c  = |mismatch_c;
    assign err_pop_c  = popcount(POP_MAX_W'(mismatch_c));
    assign ctrl_pop_c = popcount(POP_MAX_W'(ctrl_in));
    assign err_sum_c  = {1'b0, err_q} + 33'(err_pop_c);
    assign dsum_c     = dacc_q + (CW'(LANES) - CW'(ctrl_pop_c));
    assign csum_c     = cacc_q + CW'(ctrl_pop_c);
    assign dscaled_c  = 32'(dsum_c) * 32'd100;

    // Next-state logic; clear overrides window close and lock transitions.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        wcnt_d     = wcnt_q;
        dacc_d     = dacc_q;
        cacc_d     = cacc_q;
        dcnt_d     = dcnt_q;
        ccnt_d     = ccnt_q;
        ratio_d    = ratio_q;
        done_d     = 1'b0;
        err_d      = err_sum_c[32] ? 32'hFFFF_FFFF : err_sum_c[31:0];
        lane_err_d = mismatch_c;

        if (clear) begin
            state_d    = HUNT;
            run_d      = '0;
            wcnt_d     = '0;
            dacc_d     = '0;
            cacc_d     = '0;
            dcnt_d     = '0;
            ccnt_d     = '0;
            ratio_d    = 1'b0;
            err_d      = '0;
            lane_err_d = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (errored_c) begin
                        run_d = '0;
                    end else if (run_q == RW'(LOCK_CYCLES - 1)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                LOCKED: begin
                    if (!errored_c) begin
                        run_d = '0;
                    end else if (run_q == RW'(UNLOCK_CYCLES - 1)) begin
                        state_d = HUNT;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                default: state_d = HUNT;
            endcase

            if (wcnt_q == WW'(WINDOW_CYCLES - 1)) begin
                wcnt_d  = '0;
                dacc_d  = '0;
                cacc_d  = '0;
                dcnt_d  = dsum_c;
                ccnt_d  = csum_c;
                ratio_d = (dscaled_c >= LO_T) && (dscaled_c <= HI_T);
                done_d  = 1'b1;
            end else begin
                wcnt_d = wcnt_q + WW'(1);
                dacc_d = dsum_c;
                cacc_d = csum_c;
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            run_q      <= '0;
            wcnt_q     <= '0;
            dacc_q     <= '0;
            cacc_q     <= '0;
            dcnt_q     <= '0;
            ccnt_q     <= '0;
            ratio_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            lane_err_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            wcnt_q     <= wcnt_d;
            dacc_q     <= dacc_d;
            cacc_q     <= cacc_d;
            dcnt_q     <= dcnt_d;
            ccnt_q     <= ccnt_d;
            ratio_q    <= ratio_d;
            done_q     <= done_d;
            err_q      <= err_d;
            lane_err_q <= lane_err_d;
            locked_q   <= locked_d;
        end
    end

    assign lane_err    = lane_err_q;
    assign locked      = locked_q;
    assign err_count   = err_q;
    assign data_count  = dcnt_q;
    assign ctrl_count  = ccnt_q;
    assign window_done = done_q;
    assign ratio_ok    = ratio_q;

endmodule

// File: tb/tb_signal_checker.sv
// Scoreboard bench for signal_checker with a short ratio window.
module tb_signal_checker;

    localparam int unsigned DW      = 64;
    localparam int unsigned LANES   = 8;
    localparam int unsigned WIN     = 10;
    localparam int unsigned LOCKC   = 16;
    localparam int unsigned UNLOCKC = 4;
    localparam int unsigned PROB    = 70;
    localparam int unsigned TOL     = 10;
    localparam int unsigned CW      = $clog2(WIN * LANES + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     data_in;
    logic [LANES-1:0]  ctrl_in;
    logic              clear;
    logic [LANES-1:0]  lane_err;
    logic              locked;
    logic [31:0]       err_count;
    logic [CW-1:0]     data_count;
    logic [CW-1:0]     ctrl_count;
    logic              window_done;
    logic              ratio_ok;

    always #5 clk = ~clk;

    signal_checker #(
        .DATA_WIDTH            (DW),
        .DATA_CHAR_PATTERN     (8'hAA),
        .CTRL_CHAR_PATTERN     (8'h55),
        .DATA_CHAR_PROBABILITY (PROB),
        .RATIO_TOLERANCE       (TOL),
        .WINDOW_CYCLES         (WIN),
        .LOCK_CYCLES           (LOCKC),
        .UNLOCK_CYCLES         (UNLOCKC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .ctrl_in     (ctrl_in),
        .clear       (clear),
        .lane_err    (lane_err),
        .locked      (locked),
        .err_count   (err_count),
        .data_count  (data_count),
        .ctrl_count  (ctrl_count),
        .window_done (window_done),
        .ratio_ok    (ratio_ok)
    );

    typedef struct {
        logic [LANES-1:0] lane_err;
        logic             locked;
        logic [31:0]      err;
        int               dcnt;
        int               ccnt;
        logic             done;
        logic             ratio;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    longint m_err;
    bit     m_locked;
    int     m_run, m_wcnt, m_dacc, m_cacc, m_dcnt, m_ccnt;
    bit     m_ratio;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_locked = 0; m_run = 0; m_wcnt = 0;
        m_dacc = 0; m_cacc = 0; m_dcnt = 0; m_ccnt = 0; m_ratio = 0;
    endtask

    // Reference behaviour for one sampled cycle.
    task automatic model_step(input logic [DW-1:0] d, input logic [LANES-1:0] c,
                              input bit clr, output exp_t e);
        int               nerr = 0;
        int               nctl = 0;
        logic [LANES-1:0] le;
        logic [7:0]       want;
        int               lo, hi, t;
        for (int i = 0; i < int'(LANES); i++) begin
            want  = c[i] ? 8'h55 : 8'hAA;
            le[i] = (d[i*8 +: 8] != want);
            nerr += int'(le[i]);
            nctl += int'(c[i]);
        end
        e.done = 1'b0;
        if (clr) begin
            model_reset();
            le = '0;
        end else begin
            m_err += nerr;
            if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
            if (!m_locked) begin
                if (nerr == 0) begin
                    m_run++;
                    if (m_run == int'(LOCKC)) begin m_locked = 1; m_run = 0; end
                end else m_run = 0;
            end else begin
                if (nerr != 0) begin
                    m_run++;
                    if (m_run == int'(UNLOCKC)) begin m_locked = 0; m_run = 0; end
                end else m_run = 0;
            end
            m_dacc += int'(LANES) - nctl;
            m_cacc += nctl;
            if (m_wcnt == int'(WIN) - 1) begin
                t  = int'(WIN * LANES);
                lo = (PROB > TOL) ? int'(PROB - TOL) : 0;
                hi = (PROB + TOL > 100) ? 100 : int'(PROB + TOL);
                m_dcnt  = m_dacc;
                m_ccnt  = m_cacc;
                m_ratio = (m_dacc * 100 >= lo * t) && (m_dacc * 100 <= hi * t);
                e.done  = 1'b1;
                m_wcnt  = 0; m_dacc = 0; m_cacc = 0;
            end else m_wcnt++;
        end
        e.lane_err = le;
        e.locked   = m_locked;
        e.err      = m_err[31:0];
        e.dcnt     = m_dcnt;
        e.ccnt     = m_ccnt;
        e.ratio    = m_ratio;
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        chk("lane_err",    32'(lane_err),    32'(e.lane_err));
        chk("locked",      32'(locked),      32'(e.locked));
        chk("err_count",   err_count,        e.err);
        chk("data_count",  32'(data_count),  32'(e.dcnt));
        chk("ctrl_count",  32'(ctrl_count),  32'(e.ccnt));
        chk("window_done", 32'(window_done), 32'(e.done));
        chk("ratio_ok",    32'(ratio_ok),    32'(e.ratio));
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic [LANES-1:0] c, input bit clr);
        exp_t e;
        @(negedge clk);
        data_in = d;
        ctrl_in = c;
        clear   = clr;
        model_step(d, c, clr, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    function automatic logic [DW-1:0] make_data(input logic [LANES-1:0] c);
        logic [DW-1:0] d;
        for (int i = 0; i < int'(LANES); i++) d[i*8 +: 8] = c[i] ? 8'h55 : 8'hAA;
        return d;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_lane_err"}, 32'(lane_err), 32'd0);
        chk({tag, "_locked"},   32'(locked),   32'd0);
        chk({tag, "_err"},      err_count,     32'd0);
        chk({tag, "_dcnt"},     32'(data_count), 32'd0);
        chk({tag, "_ccnt"},     32'(ctrl_count), 32'd0);
        chk({tag, "_done"},     32'(window_done), 32'd0);
        chk({tag, "_ratio"},    32'(ratio_ok),  32'd0);
    endtask

    initial begin
        logic [DW-1:0]    clean;
        logic [DW-1:0]    d;
        logic [LANES-1:0] c;
        int               edge_at;

        clean   = make_data('0);
        data_in = clean;
        ctrl_in = '0;
        clear   = 1'b0;
        model_reset();

        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("rst");
        end
        #1 rst_n = 1'b1;

        // Lock acquisition on a clean all-data stream.
        edge_at = 0;
        for (int i = 1; i <= 20; i++) begin
            drive(clean, '0, 1'b0);
            if (locked && edge_at == 0) edge_at = i;
        end
        chk("lock_latency", 32'(edge_at), 32'(LOCKC));

        // Single corrupted lane while locked.
        d = clean;
        d[23:16] = 8'h00;
        drive(d, '0, 1'b0);
        chk("single_lane_err", 32'(lane_err), 32'h04);
        chk("single_err_cnt",  err_count,     32'd1);
        chk("single_locked",   32'(locked),   32'd1);
        drive(clean, '0, 1'b0);

        // Four errored cycles drop lock, sixteen clean cycles regain it.
        d = clean;
        d[7:0]   = 8'h55;
        d[63:56] = 8'h55;
        repeat (4) drive(d, '0, 1'b0);
        chk("unlock_locked", 32'(locked),  32'd0);
        chk("unlock_err",    err_count,    32'd9);
        repeat (16) drive(clean, '0, 1'b0);
        chk("relock", 32'(locked), 32'd1);

        // Ratio windows: 70% then 50% data characters.
        while (m_wcnt != 0) drive(clean, '0, 1'b0);
        repeat (2) begin
            for (int k = 0; k < int'(WIN); k++) begin
                c = (k < 8) ? 8'h07 : 8'h00;
                drive(make_data(c), c, 1'b0);
            end
            chk("r70_done",  32'(window_done), 32'd1);
            chk("r70_dcnt",  32'(data_count),  32'd56);
            chk("r70_ccnt",  32'(ctrl_count),  32'd24);
            chk("r70_ratio", 32'(ratio_ok),    32'd1);
        end
        for (int k = 0; k < int'(WIN); k++) drive(make_data(8'h0F), 8'h0F, 1'b0);
        chk("r50_dcnt",  32'(data_count), 32'd40);
        chk("r50_ratio", 32'(ratio_ok),   32'd0);
        drive(clean, '0, 1'b0);
        chk("hold_dcnt", 32'(data_count), 32'd40);

        // Saturation of the error counter.
        #1 force dut.err_q = 32'hFFFF_FFFE;
        #1 release dut.err_q;
        m_err = 64'hFFFF_FFFE;
        drive('0, '0, 1'b0);
        chk("sat_err", err_count, 32'hFFFF_FFFF);
        drive('0, '0, 1'b0);
        chk("sat_hold", err_count, 32'hFFFF_FFFF);

        // Clear coinciding with window close.
        while (m_wcnt != int'(WIN) - 1) drive(clean, '0, 1'b0);
        drive(clean, '0, 1'b1);
        chk("clr_done",   32'(window_done), 32'd0);
        chk("clr_dcnt",   32'(data_count),  32'd0);
        chk("clr_err",    err_count,        32'd0);
        chk("clr_locked", 32'(locked),      32'd0);
        edge_at = 0;
        for (int i = 1; i <= int'(WIN) + 2; i++) begin
            drive(clean, '0, 1'b0);
            if (window_done && edge_at == 0) edge_at = i;
        end
        chk("clr_window", 32'(edge_at), 32'(WIN));

        // Random generator-like link with matching patterns.
        for (int w = 0; w < 20 * int'(WIN); w++) begin
            for (int i = 0; i < int'(LANES); i++) c[i] = ($urandom_range(99) >= PROB);
            drive(make_data(c), c, 1'b0);
        end
        chk("link_err",    err_count,      32'd0);
        chk("link_locked", 32'(locked),    32'd1);

        // Asynchronous reset in the middle of a window.
        while (m_wcnt != 4) drive(clean, '0, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_zero("arst");
        model_reset();
        @(posedge clk);
        #1 check_zero("arst_hold");
        #1 rst_n = 1'b1;
        edge_at = 0;
        for (int i = 1; i <= int'(WIN) + 1; i++) begin
            drive(clean, '0, 1'b0);
            if (window_done && edge_at == 0) edge_at = i;
        end
        chk("arst_window", 32'(edge_at), 32'(WIN));

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
